// File: rtl/tour_sequencer_if.sv
// Command/response link between the tour sequencer and RemoteComm.
interface tour_sequencer_if;
  logic [15:0] cmd;
  logic        send_cmd;
  logic        cmd_sent;
  logic        resp_rdy;
  logic [7:0]  resp;

  modport master (
    output cmd,
    output send_cmd,
    input  cmd_sent,
    input  resp_rdy,
    input  resp
  );

  modport slave (
    input  cmd,
    input  send_cmd,
    output cmd_sent,
    output resp_rdy,
    output resp
  );
endinterface

// File: rtl/tour_sequencer.sv
// Buffers compact move entries, expands them into Knight commands and issues
// them one at a time to RemoteComm, retiring each on an 8'hA5 acknowledgement.
module tour_sequencer #(
  parameter int unsigned DEPTH   = 16,
  parameter int unsigned TMO_CYC = 10_000_000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  input  logic                   start,
  input  logic                   abort,
  tour_sequencer_if.master       rc,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [1:0]             err_code,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count,
  output logic [7:0]             retired
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TMO_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TMO_CYC - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [7:0]    ACK      = 8'hA5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_SENT,
    S_WAIT_RESP,
    S_ERR
  } state_t;

  state_t state, state_nxt;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_p1;
  logic [CW-1:0] count_nxt;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          push, pop;
  logic          clr_run, done_nxt, tmo_clr, err_set, code_set;
  logic [1:0]    code_nxt;
  logic [7:0]    head_nxt;
  logic [15:0]   cmd_nxt;

  // Entry -> 16-bit Knight command.
  function automatic logic [15:0] expand(input logic [7:0] e);
    logic [7:0] heading;
    case (e[5:4])
      2'b00:   heading = 8'h00;
      2'b01:   heading = 8'h3F;
      2'b10:   heading = 8'h7F;
      default: heading = 8'hBF;
    endcase
    if (e[7]) return 16'h2000;
    return {(e[6] ? 4'h5 : 4'h4), heading, e[3:0]};
  endfunction

  assign push      = wr_en && !full && !abort;
  assign rd_ptr_p1 = rd_ptr + AW'(1);
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign tmo_hit   = (tmo_cnt == TMO_LAST);

  // The command is loaded on the edge into ISSUE, so it must look ahead past a
  // pop in progress; with a single entry left the next head is this cycle's push.
  assign head_nxt = (state == S_IDLE)      ? mem[rd_ptr]    :
                    (count > CW'(1))       ? mem[rd_ptr_p1] : wr_data;
  assign cmd_nxt  = expand(head_nxt);

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    clr_run   = 1'b0;
    done_nxt  = 1'b0;
    tmo_clr   = 1'b0;
    err_set   = 1'b0;
    code_set  = 1'b0;
    code_nxt  = 2'b00;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          clr_run = 1'b1;
          if (!empty) state_nxt = S_ISSUE;
          else        done_nxt  = 1'b1;
        end
      end
      S_ISSUE: state_nxt = S_WAIT_SENT;
      S_WAIT_SENT: begin
        if (rc.cmd_sent) begin
          state_nxt = S_WAIT_RESP;
          tmo_clr   = 1'b1;
        end
      end
      S_WAIT_RESP: begin
        if (rc.resp_rdy) begin
          if (rc.resp == ACK && !empty) begin
            pop = 1'b1;
            if (count > CW'(1) || push) begin
              state_nxt = S_ISSUE;
            end else begin
              state_nxt = S_IDLE;
              done_nxt  = 1'b1;
            end
          end else begin
            state_nxt = S_ERR;
            code_set  = 1'b1;
            code_nxt  = 2'b01;
          end
        end else if (tmo_hit) begin
          state_nxt = S_ERR;
          code_set  = 1'b1;
          code_nxt  = 2'b10;
        end
      end
      S_ERR: begin
        err_set   = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // abort overrides every transition and side effect of this cycle
    if (abort) begin
      state_nxt = S_IDLE;
      pop       = 1'b0;
      clr_run   = 1'b0;
      done_nxt  = 1'b0;
      err_set   = 1'b0;
      code_set  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || tmo_clr)                          tmo_cnt <= '0;
    else if (state == S_WAIT_RESP && !tmo_hit)   tmo_cnt <= tmo_cnt + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // FIFO pointers and registered status.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr_p1;
      count <= count_nxt;
      full  <= (count_nxt == CNT_FULL);
      empty <= (count_nxt == '0);
    end
  end

  // Registered outputs, derived from the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      rc.cmd      <= 16'h0000;
      rc.send_cmd <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      err_code    <= 2'b00;
      retired     <= 8'd0;
    end else begin
      rc.send_cmd <= (state_nxt == S_ISSUE);
      busy        <= (state_nxt != S_IDLE);
      done        <= done_nxt;
      if (state_nxt == S_ISSUE) rc.cmd <= cmd_nxt;
      if (abort || clr_run) begin
        err      <= 1'b0;
        err_code <= 2'b00;
      end else begin
        if (err_set)  err      <= 1'b1;
        if (code_set) err_code <= code_nxt;
      end
      if (clr_run)                         retired <= 8'd0;
      else if (pop && retired != 8'hFF)    retired <= retired + 8'd1;
    end
  end

  a_send_pulse: assert property (@(posedge clk) disable iff (rst)
    rc.send_cmd |=> !rc.send_cmd);
  a_count_range: assert property (@(posedge clk) disable iff (rst)
    count <= CNT_FULL);

endmodule

// File: tb/tb_tour_sequencer.sv
// Bench for tour_sequencer: RemoteComm responder model, queue-based reference
// model of the entry FIFO, and a monitor that scores every issued command.
module tb_tour_sequencer;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 100;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  typedef struct {
    bit          none;
    byte unsigned resp;
    int          sent_dly;
    int          resp_dly;
    bit          push_en;
    byte unsigned push_b;
    int          exp_cnt;
  } rsp_t;

  logic          clk = 1'b0;
  logic          rst, wr_en, start, abort;
  logic [7:0]    wr_data;
  logic          busy, done, err, full, empty;
  logic [1:0]    err_code;
  logic [CW-1:0] count;
  logic [7:0]    retired;

  tour_sequencer_if rc();

  tour_sequencer #(.DEPTH(DEPTH), .TMO_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .start(start), .abort(abort), .rc(rc),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .full(full), .empty(empty), .count(count), .retired(retired)
  );

  int n_chk = 0, n_fail = 0;
  int cyc = 0, n_done = 0, err_due = -1, ack_cyc = 0;
  bit ack_pend = 1'b0;
  byte unsigned mq[$];
  logic [15:0]  exp_cmd[$];
  rsp_t         plan[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Command derived arithmetically from the entry fields.
  function automatic logic [15:0] ref_cmd(input byte unsigned e);
    int d = (int'(e) >> 4) & 3;
    int h = (d == 0) ? 0 : d * 64 - 1;
    int op = 4 + ((int'(e) >> 6) & 1);
    if (((int'(e) >> 7) & 1) == 1) return 16'h2000;
    return 16'((op << 12) | (h << 4) | (int'(e) & 15));
  endfunction

  function automatic rsp_t mk(input bit none, input byte unsigned resp, input int rdly,
                              input bit pe, input byte unsigned pb);
    rsp_t p;
    p.none = none; p.resp = resp; p.resp_dly = rdly;
    p.sent_dly = int'($urandom_range(0, 3));
    p.push_en = pe; p.push_b = pb; p.exp_cnt = 0;
    return p;
  endfunction

  // RemoteComm model: answers each send_cmd according to the plan queue.
  initial begin : responder
    rsp_t p;
    bit hold;
    hold = 1'b0;
    rc.cmd_sent = 1'b0; rc.resp_rdy = 1'b0; rc.resp = 8'h00;
    forever begin
      if (!hold) @(negedge clk);
      hold = 1'b0;
      if (rc.send_cmd === 1'b1 && plan.size() > 0) begin
        p = plan.pop_front();
        @(posedge clk); #1;
        repeat (p.sent_dly) begin @(posedge clk); #1; end
        rc.cmd_sent = 1'b1;
        if (p.none) err_due = cyc + int'(TMO) + 2;
        @(posedge clk); #1;
        rc.cmd_sent = 1'b0;
        if (!p.none) begin
          repeat (p.resp_dly - 1) begin @(posedge clk); #1; end
          rc.resp_rdy = 1'b1; rc.resp = p.resp;
          if (p.push_en) begin wr_en = 1'b1; wr_data = p.push_b; end
          @(posedge clk); #1;
          rc.resp_rdy = 1'b0;
          if (p.push_en) begin
            wr_en = 1'b0;
            @(negedge clk);
            chk("push_pop_same_cycle_count", int'(count), p.exp_cnt);
            hold = 1'b1;
          end
        end
      end
    end
  end

  // Scoreboard monitor: pops the expected command on every send_cmd.
  initial begin : monitor
    logic prev_send, prev_done, prev_err;
    prev_send = 1'b0; prev_done = 1'b0; prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rc.send_cmd === 1'b1) begin
        chk("send_cmd_width", int'(prev_send), 0);
        if (exp_cmd.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_send_cmd: got cmd 0x%0h expected none (cycle %0d)", rc.cmd, cyc);
        end else begin
          chk("cmd", int'(rc.cmd), int'(exp_cmd.pop_front()));
        end
        chk("busy_with_send", int'(busy), 1);
        if (ack_pend) begin chk("ack_to_send_latency", cyc - ack_cyc, 1); ack_pend = 1'b0; end
      end
      if (done === 1'b1) begin
        n_done++;
        chk("done_width", int'(prev_done), 0);
        if (ack_pend) begin chk("ack_to_done_latency", cyc - ack_cyc, 1); ack_pend = 1'b0; end
      end
      if (err === 1'b1 && prev_err === 1'b0) begin
        if (err_due < 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_err: got err=1 expected 0 (cycle %0d)", cyc);
        end else chk("err_latency", cyc, err_due);
        err_due = -1;
      end
      if (rc.resp_rdy === 1'b1 && busy === 1'b1) begin
        if (rc.resp == 8'hA5) begin ack_cyc = cyc; ack_pend = 1'b1; end
        else err_due = cyc + 2;
      end
      prev_send = rc.send_cmd; prev_done = done; prev_err = err;
    end
  end

  task automatic push(input byte unsigned b);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_data = b;
    if (mq.size() < DEPTH) mq.push_back(b);
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_cmd_sent(input string tag);
    int k = 0;
    while (rc.cmd_sent !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    chk({tag, "_cmd_sent_seen"}, int'(rc.cmd_sent), 1);
  endtask

  // Predict the run from the model queue and plan, then run it and check.
  task automatic do_run(input string tag);
    int r = 0, n0, k = 0;
    bit e = 1'b0, was_empty;
    logic [1:0] code = 2'b00;
    was_empty = (mq.size() == 0);
    for (int i = 0; i < plan.size(); i++) begin
      if (mq.size() == 0) break;
      exp_cmd.push_back(ref_cmd(mq[0]));
      if (plan[i].none) begin e = 1'b1; code = 2'b10; break; end
      if (plan[i].resp != 8'hA5) begin e = 1'b1; code = 2'b01; break; end
      plan[i].exp_cnt = mq.size();
      void'(mq.pop_front());
      if (plan[i].push_en) mq.push_back(plan[i].push_b);
      if (r < 255) r++;
    end
    n0 = n_done;
    pulse_start();
    @(negedge clk);
    if (was_empty) chk({tag, "_empty_start_done"}, int'(done), 1);
    else begin
      chk({tag, "_start_to_send"}, int'(rc.send_cmd), 1);
      chk({tag, "_busy_rise"}, int'(busy), 1);
    end
    while (busy === 1'b1 && k < 3000) begin @(negedge clk); k++; end
    chk({tag, "_idle_reached"}, int'(busy), 0);
    repeat (2) @(negedge clk);
    chk({tag, "_err"}, int'(err), int'(e));
    chk({tag, "_err_code"}, int'(err_code), int'(code));
    chk({tag, "_retired"}, int'(retired), r);
    chk({tag, "_count"}, int'(count), mq.size());
    chk({tag, "_empty"}, int'(empty), int'(mq.size() == 0));
    chk({tag, "_full"}, int'(full), int'(mq.size() == DEPTH));
    chk({tag, "_done_pulses"}, n_done - n0, e ? 0 : 1);
    chk({tag, "_cmds_outstanding"}, exp_cmd.size(), 0);
    plan.delete();
    exp_cmd.delete();
  endtask

  task automatic check_idle_reset(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_send_cmd"}, int'(rc.send_cmd), 0);
    chk({tag, "_empty"}, int'(empty), 1);
    chk({tag, "_count"}, int'(count), 0);
    chk({tag, "_full"}, int'(full), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_err_code"}, int'(err_code), 0);
    chk({tag, "_retired"}, int'(retired), 0);
  endtask

  initial begin : stim
    int n0;
    rst = 1'b1; wr_en = 1'b0; wr_data = 8'h00; start = 1'b0; abort = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_idle_reset("reset");
    chk("reset_cmd", int'(rc.cmd), 0);
    chk("reset_done", int'(done), 0);

    // calibrate entry
    push(8'h80);
    plan.push_back(mk(1'b0, 8'hA5, 3, 1'b0, 8'h00));
    do_run("cal");

    // four moves back to back
    push(8'h01); push(8'h12); push(8'h61); push(8'h72);
    repeat (4) plan.push_back(mk(1'b0, 8'hA5, int'($urandom_range(1, 10)), 1'b0, 8'h00));
    do_run("moves");

    // bad response on the second command, then retry from the failing head
    push(8'h01); push(8'h12); push(8'h61); push(8'h72);
    plan.push_back(mk(1'b0, 8'hA5, 2, 1'b0, 8'h00));
    plan.push_back(mk(1'b0, 8'h5A, 4, 1'b0, 8'h00));
    do_run("badresp");
    repeat (3) plan.push_back(mk(1'b0, 8'hA5, 2, 1'b0, 8'h00));
    do_run("retry");

    // timeout, then a response on the final count cycle
    push(8'h23);
    plan.push_back(mk(1'b1, 8'h00, 0, 1'b0, 8'h00));
    do_run("timeout");
    plan.push_back(mk(1'b0, 8'hA5, int'(TMO), 1'b0, 8'h00));
    do_run("last_cycle_resp");

    // start with nothing queued
    do_run("empty_start");

    // overflow: the extra push is dropped
    for (int i = 0; i <= int'(DEPTH); i++) push(8'(8'h40 + i));
    @(negedge clk);
    chk("overflow_full", int'(full), 1);
    chk("overflow_count", int'(count), int'(DEPTH));
    repeat (DEPTH) plan.push_back(mk(1'b0, 8'hA5, int'($urandom_range(1, 5)), 1'b0, 8'h00));
    do_run("drain_full");

    // push in the same cycle as the pop of the last entry keeps the run going
    push(8'h9F);
    plan.push_back(mk(1'b0, 8'hA5, 5, 1'b1, 8'h35));
    plan.push_back(mk(1'b0, 8'hA5, 2, 1'b0, 8'h00));
    do_run("push_pop");

    // abort while waiting for the response; the late response is ignored
    push(8'h05); push(8'h16); push(8'h27);
    plan.push_back(mk(1'b0, 8'hA5, 60, 1'b0, 8'h00));
    exp_cmd.push_back(ref_cmd(mq[0]));
    n0 = n_done;
    pulse_start();
    wait_cmd_sent("abort");
    repeat (5) @(negedge clk);
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    mq.delete();
    @(negedge clk);
    check_idle_reset("abort");
    repeat (80) @(negedge clk);
    check_idle_reset("abort_late");
    chk("abort_no_done", n_done - n0, 0);
    chk("abort_cmds_outstanding", exp_cmd.size(), 0);
    plan.delete(); exp_cmd.delete();

    // synchronous reset in the middle of a run
    push(8'h31); push(8'h42); push(8'h53);
    plan.push_back(mk(1'b0, 8'hA5, 40, 1'b0, 8'h00));
    exp_cmd.push_back(ref_cmd(mq[0]));
    n0 = n_done;
    pulse_start();
    wait_cmd_sent("midrst");
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    mq.delete();
    @(negedge clk);
    check_idle_reset("midrst");
    chk("midrst_cmd", int'(rc.cmd), 0);
    repeat (60) @(negedge clk);
    check_idle_reset("midrst_late");
    chk("midrst_no_done", n_done - n0, 0);
    plan.delete(); exp_cmd.delete();

    // randomized runs against the reference model
    for (int it = 0; it < 8; it++) begin
      int n = int'($urandom_range(1, DEPTH));
      for (int j = 0; j < n; j++) push(8'($urandom_range(0, 255)));
      for (int j = 0; j < mq.size(); j++) begin
        byte unsigned rb = 8'hA5;
        if ($urandom_range(0, 7) == 0) begin
          rb = 8'($urandom_range(0, 255));
          if (rb == 8'hA5) rb = 8'h00;
        end
        plan.push_back(mk(1'b0, rb, int'($urandom_range(1, 30)), 1'b0, 8'h00));
      end
      do_run("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tour_sequencer.md
# tour_sequencer

Tour sequencer for the Knight's Tour system. It buffers a list of compact move entries, expands each entry into a 16-bit Knight command, and issues the commands one at a time through the RemoteComm command/response handshake. A command is retired only after an 8'hA5 acknowledgement arrives. The block sits on the host side between a tour-generation source and RemoteComm. It replaces hand-sequenced calibrate and move tasks with hardware that issues back-to-back moves, detects timeouts and reports errors.

## Interface
Parameters:
- DEPTH, 16: entry FIFO depth; power of two, ≥ 2.
- TMO_CYC, 10_000_000: maximum clk cycles to wait for resp_rdy after cmd_sent.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  push wr_data into the FIFO. Ignored when full.
- wr_data  in  8  entry: [7] cal, [6] fanfare, [5:4] dir, [3:0] squares.
- start  in  1  one-cycle pulse; begins draining the FIFO from IDLE.
- abort  in  1  one-cycle pulse; returns to IDLE and flushes the FIFO.
- cmd  out  16  command to RemoteComm. Held stable from send_cmd until cmd_sent.
- send_cmd  out  1  one-cycle request to RemoteComm.
- cmd_sent  in  1  RemoteComm finished transmitting cmd.
- resp_rdy  in  1  one-cycle pulse; resp is valid.
- resp  in  8  response byte.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the FIFO drains with no error.
- err  out  1  sticky error flag; cleared by start, abort or rst.
- err_code  out  2  01 = bad response, 10 = timeout, 00 = none.
- full, empty  out  1  FIFO status.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.
- retired  out  8  commands acknowledged since the last start; saturates at 255.

## Operation
Command expansion, combinational from the FIFO head:
- cal=1 → cmd = 16'h2000. All other fields are ignored.
- cal=0 → cmd = {opcode, heading, squares}.
  - opcode = 4'h5 when fanfare=1, else 4'h4.
  - heading: dir 00 → 8'h00 (N), 01 → 8'h3F (W), 10 → 8'h7F (S), 11 → 8'hBF (E).
  - squares = wr_data[3:0], passed through.
- The cmd register is loaded on entry to ISSUE and is not changed until the next ISSUE.

FIFO:
- Circular buffer with pointer wrap-around.
- A push while full is dropped and count is unchanged.
- Pushes are legal in every state, including during a run.
- Push and pop in the same cycle leave count unchanged.
- A pop happens only on an A5 acknowledgement.

State machine:
- IDLE:
  - start and !empty → ISSUE. Clears retired, err and err_code.
  - start and empty → done pulse next cycle; stay in IDLE.
- ISSUE: assert send_cmd for one cycle and latch cmd → WAIT_SENT.
- WAIT_SENT: wait for cmd_sent → WAIT_RESP. Clear the timeout counter.
- WAIT_RESP: the timeout counter increments each cycle.
  - resp_rdy and resp == 8'hA5 → pop, retired++.
    - If the FIFO is now non-empty (taking a same-cycle push into account) → ISSUE.
    - Otherwise → IDLE with a done pulse.
  - resp_rdy and resp != 8'hA5 → ERR with err_code 01. No pop.
  - counter reaches TMO_CYC−1 without resp_rdy → ERR with err_code 10.
  - resp_rdy on the final count cycle counts as a response, not a timeout.
- ERR: single cycle; set err → IDLE. The failing entry stays at the FIFO head, so a later start retries it.
- abort in any state:
  - next state IDLE, FIFO flushed, send_cmd low.
  - err and err_code are cleared.
  - abort has priority over every transition in the same cycle.
- Outputs and responses outside their expected windows:
  - resp_rdy outside WAIT_RESP is ignored.
  - cmd_sent outside WAIT_SENT is ignored.

## Timing
- Reset values:
  - state IDLE.
  - cmd 16'h0000; send_cmd, busy, done, err, full all 0; err_code 00.
  - empty 1; count 0; retired 0; FIFO pointers 0.
- Reset mid-operation behaves exactly like reset from power-up. No command is reissued.
- start is sampled at a rising edge:
  - send_cmd is high on the edge after start, i.e. latency 1 cycle (IDLE→ISSUE).
  - the ISSUE state is visible on that cycle, so busy rises together with send_cmd.
- Acknowledgement to next command: the next send_cmd follows 1 cycle after the resp_rdy cycle (WAIT_RESP→ISSUE→send).
- done rises 1 cycle after the final resp_rdy and lasts exactly one cycle.
- err rises 2 cycles after the failing resp_rdy or timeout cycle (via ERR) and remains high until cleared.
- Pointers, count and full/empty are registered outputs and update 1 cycle after the wr_en or pop edge.

## Test plan
- Reset, then push 8'h80 and pulse start → cmd=16'h2000, send_cmd high 1 cycle later. Model returns cmd_sent, then resp A5 → done pulse, retired=1, empty=1.
- Push 8'h01, 8'h12, 8'h61, 8'h72 and start → cmds issued in order: 16'h4001, 16'h43F2, 16'h57F1, 16'h5BF2. done after the 4th A5; retired=4.
- Respond 8'h5A to the second command → err=1, err_code=01, count=3, head still 8'h12. A new start reissues 16'h43F2.
- With TMO_CYC=100, withhold resp_rdy → err_code=10 exactly 100 cycles after cmd_sent, then IDLE. Assert resp_rdy on cycle 99 in a second run → no error.
- Push DEPTH+1 entries → full=1, count=DEPTH, last push dropped. Push and pop in the same cycle → count unchanged.
- Abort during WAIT_RESP, and separately rst asserted mid-run → IDLE, empty=1, busy=0, no further send_cmd. A late resp_rdy afterwards is ignored.
